// File: rtl/decoder_pkg.sv
// Shared types and helpers for the sequenced one-hot decoder.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  localparam int unsigned MAX_W     = 6;
  localparam int unsigned MAX_OUT_W = 64;

  // Counter width that never collapses to zero bits for tiny reload values.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = (n > 32'd1) ? $clog2(n) : 32'd1;
    return r;
  endfunction

  // One-hot of idx_v; indices outside a width-bit range decode to all-zero.
  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_W-1:0] idx_v,
                                                  input int unsigned width);
    logic [MAX_OUT_W-1:0] oh_v;
    oh_v = 64'd1 << idx_v;
    if ((width < MAX_W) && ({26'd0, idx_v} >= (32'd1 << width))) begin
      oh_v = 64'd0;
    end else begin
      oh_v = oh_v;
    end
    return oh_v;
  endfunction

endpackage

// File: rtl/decoder_seq_down_counter.sv
// Saturating down counter with synchronous reload and a zero flag.
module down_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] reload_val,
  output logic [W-1:0] cnt,
  output logic         zero
);

  assign zero = (cnt == '0);

  // Reload has priority; decrement stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= reload_val;
    end else if (dec && !zero) begin
      cnt <= cnt - W'(1);
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/decoder_seq.sv
// Registered WIDTH-to-2^WIDTH one-hot decoder with a held load path and a
// free-running scan mode.
module decoder_seq
  import decoder_pkg::*;
#(
  parameter  int unsigned WIDTH    = 2,
  parameter  int unsigned HOLD_CYC = 1,
  parameter  int unsigned SCAN_DIV = 4,
  localparam int unsigned OUT_W    = 2 ** WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in,
  output logic             in_ready,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  output logic [WIDTH-1:0] idx
);

  localparam int unsigned HW = clog2_min1(HOLD_CYC);
  localparam int unsigned SW = clog2_min1(SCAN_DIV);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYC - 32'd1);
  localparam logic [SW-1:0] SCAN_RELOAD = SW'(SCAN_DIV - 32'd1);

  state_t               state_r;
  state_t               state_nxt_s;
  logic                 armed_r;
  logic [WIDTH-1:0]     idx_nxt_s;
  logic                 out_valid_nxt_s;
  logic [OUT_W-1:0]     out_nxt_s;
  logic [MAX_OUT_W-1:0] oh_full_s;
  logic                 xfer_s;
  logic                 restore_s;
  logic                 hold_load_s;
  logic                 hold_dec_s;
  logic                 hold_zero_s;
  logic [HW-1:0]        hold_cnt_s;
  logic                 scan_load_s;
  logic                 scan_dec_s;
  logic                 scan_zero_s;
  logic [SW-1:0]        scan_cnt_s;

  down_counter #(.W(HW)) u_hold_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (hold_load_s),
    .dec        (hold_dec_s),
    .reload_val (HOLD_RELOAD),
    .cnt        (hold_cnt_s),
    .zero       (hold_zero_s)
  );

  down_counter #(.W(SW)) u_scan_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (scan_load_s),
    .dec        (scan_dec_s),
    .reload_val (SCAN_RELOAD),
    .cnt        (scan_cnt_s),
    .zero       (scan_zero_s)
  );

  // armed_r keeps in_ready low until the first edge after reset release.
  assign in_ready  = armed_r & en & ~mode &
                     ((state_r == IDLE) | ((state_r == HOLD) & hold_zero_s));
  assign xfer_s    = in_valid & in_ready;
  // First enabled edge after a blanked period only re-lights the output.
  assign restore_s = (state_r != IDLE) & ~out_valid;

  // Next-state, next-output and counter control.
  always_comb begin
    state_nxt_s     = state_r;
    idx_nxt_s       = idx;
    out_valid_nxt_s = 1'b0;
    hold_load_s     = 1'b0;
    hold_dec_s      = 1'b0;
    scan_load_s     = 1'b0;
    scan_dec_s      = 1'b0;
    if (!en) begin
      state_nxt_s = state_r;
    end else if (mode) begin
      out_valid_nxt_s = 1'b1;
      if (state_r != SCAN) begin
        state_nxt_s = SCAN;
        idx_nxt_s   = '0;
        scan_load_s = 1'b1;
      end else if (restore_s) begin
        scan_dec_s = 1'b0;
      end else if (scan_zero_s) begin
        idx_nxt_s   = idx + WIDTH'(1);
        scan_load_s = 1'b1;
      end else begin
        scan_dec_s = 1'b1;
      end
    end else begin
      case (state_r)
        SCAN: begin
          state_nxt_s = IDLE;
        end
        IDLE, HOLD: begin
          if (xfer_s) begin
            state_nxt_s     = HOLD;
            idx_nxt_s       = in;
            out_valid_nxt_s = 1'b1;
            hold_load_s     = 1'b1;
          end else if (state_r == HOLD) begin
            out_valid_nxt_s = 1'b1;
            hold_dec_s      = ~restore_s;
          end else begin
            out_valid_nxt_s = 1'b0;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
    oh_full_s = onehot(MAX_W'(idx_nxt_s), WIDTH);
    out_nxt_s = out_valid_nxt_s ? oh_full_s[OUT_W-1:0] : '0;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      armed_r   <= 1'b0;
      idx       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      armed_r   <= 1'b1;
      idx       <= idx_nxt_s;
      out       <= out_nxt_s;
      out_valid <= out_valid_nxt_s;
    end
  end

endmodule

// File: doc/decoder_seq.md
Name: decoder_seq

Overview:
Parametrised, registered binary-to-one-hot decoder. It generalises the 2-to-4 decoder to WIDTH-to-2^WIDTH and adds a valid/ready load path with a minimum hold time. It also adds an autonomous scan mode that rotates the one-hot output, for example to drive multiplexed display digits or row selects. It sits between control logic issuing select indices and the strobe/enable lines of downstream banks.

Parameters:
WIDTH, 2, index width; output width OUT_W = 2**WIDTH; legal range 1..6.
HOLD_CYC, 1, minimum cycles a loaded one-hot output is held before a new load is accepted; >= 1.
SCAN_DIV, 4, cycles each one-hot position is held in scan mode; >= 1.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
en  in  1  global enable; 0 blanks the output and freezes the counters.
mode  in  1  0 = load (handshake) mode, 1 = scan mode.
in_valid  in  1  index on `in` is valid.
in  in  WIDTH  binary index to decode.
in_ready  out  1  block can accept an index this cycle.
out  out  OUT_W  one-hot select; all-zero when blank.
out_valid  out  1  `out` holds a valid one-hot value.
idx  out  WIDTH  binary index currently driven on `out`.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - rst_n=0 forces immediately: state=IDLE, out=0, out_valid=0, idx=0, in_ready=0, hold counter=0, scan counter=0.
  - in_ready is first high in the cycle after reset deasserts, provided mode=0 and en=1.
- States: IDLE, HOLD, SCAN. All outputs are registered except in_ready, which is a combinational function of state, hold counter, mode and en.
- in_ready = en & ~mode & (state==IDLE | (state==HOLD & hold_cnt==0)).
- Load transfer:
  - A transfer occurs when in_valid & in_ready at a rising edge.
  - After that edge: out = 1<<in, idx = in, out_valid = 1, state = HOLD, hold_cnt = HOLD_CYC-1. Latency is 1 cycle.
- HOLD:
  - hold_cnt decrements each cycle while en=1 and saturates at 0.
  - out stays held indefinitely after hold_cnt reaches 0, until the next transfer or a mode change.
  - A transfer in the same cycle that hold_cnt==0 is accepted back-to-back with no bubble.
  - With HOLD_CYC=1, a new load is accepted every cycle.
- SCAN:
  - Entered when mode=1 is sampled at an edge, from any state.
  - On entry: idx=0, out=1, out_valid=1, scan_cnt=SCAN_DIV-1.
  - Each cycle with en=1: if scan_cnt==0 then idx = idx+1 (mod OUT_W, wrapping OUT_W-1 -> 0), out = 1<<(idx+1), scan_cnt = SCAN_DIV-1; otherwise scan_cnt decrements.
  - in_valid is ignored in SCAN (in_ready=0).
- Leaving SCAN: mode sampled 0 -> state=IDLE, out=0, out_valid=0, idx retained. in_ready rises in that same next cycle.
- en=0:
  - On the next edge out=0 and out_valid=0.
  - state, idx, hold_cnt and scan_cnt are frozen; in_ready=0.
  - When en returns to 1: if state!=IDLE, out is restored to 1<<idx and out_valid to 1 one cycle later, and counting resumes from the frozen values.
- Invariants: out is always zero or exactly one-hot; out == (out_valid ? 1<<idx : 0).
- Simultaneous mode=1 and in_valid=1: scan wins and no transfer occurs, since in_ready=0.
- Reset mid-operation: immediate return to reset values; no partial transfer.

Decomposition:
- Package decoder_pkg:
  - state enum (IDLE, HOLD, SCAN);
  - function onehot(idx, width);
  - localparam counter width function clog2_min1 (returns >= 1).
- One sub-module, down_counter (reload value, enable, zero flag). It is instantiated twice: once for hold and once for scan division.

Test Plan:
- Reset and load, WIDTH=2, HOLD_CYC=3: release reset, mode=0, in=2 with in_valid for 1 cycle -> next cycle out=0100, idx=2, out_valid=1; in_ready=0 for 2 cycles, then 1.
- Back-to-back loads, HOLD_CYC=1: in_valid held high with in=0,1,2,3 on consecutive cycles -> out=0001,0010,0100,1000 on consecutive cycles, in_ready constantly 1.
- Scan wrap, SCAN_DIV=2: set mode=1 -> out sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001, each value held 2 cycles, wrapping to 0001.
- Enable freeze: during scan at out=0010 with 1 cycle left, en=0 for 5 cycles -> out=0000 and out_valid=0 throughout; en=1 -> out=0010 for exactly 1 cycle, then 0100.
- Mode exit during hold, HOLD_CYC=4: load in=3, then mode=1 one cycle later -> scan starts at out=0001; mode=0 -> out=0000, out_valid=0, in_ready=1 the next cycle.
- Async reset mid-scan: pull rst_n low between edges -> out=0000, out_valid=0, idx=0 immediately without waiting for a clock; WIDTH=3 rerun confirms out=00010000 for in=4.
